bcd_serial_add_ctrl: RTL and testbench

- Sequencer that shares one 4-bit BCD digit adder across an NDIGITS-wide decimal addition, one digit per clock, least-significant digit first.
- The digit adder is binary add plus subtract-10 correction. It sits between operand capture (keypad/registers) and the decimal display drivers.
- Start/done handshake. The result is held stable for the display until the next accepted start.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and index sizing for the serial BCD adder
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a digit index; a single-digit adder still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational one-digit BCD adder (binary add, subtract-10 correction)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] d,
  output logic               cout,
  output logic               invalid
);

  logic [DIGIT_W:0] s;
  logic [DIGIT_W:0] s_adj;

  // Non-BCD nibbles go through the same formula; the result is truncated, never X.
  always_comb begin
    s       = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    s_adj   = s - (DIGIT_W+1)'(BCD_RADIX);
    cout    = (s > (DIGIT_W+1)'(BCD_MAX));
    d       = cout ? s_adj[DIGIT_W-1:0] : s[DIGIT_W-1:0];
    invalid = (a > DIGIT_W'(BCD_MAX)) || (b > DIGIT_W'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial decimal adder sequencer; BCD_DIGIT_CHECK_EN enables the invalid-digit flag
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] a_bcd,
  input  logic [DIGIT_W*NDIGITS-1:0] b_bcd,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] sum_bcd,
  output logic                       carry_out,
  output logic                       err
);

  localparam int W  = DIGIT_W * NDIGITS;
  localparam int IW = idx_width(NDIGITS);

  state_t state;
  state_t state_next;

  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [IW-1:0]      idx;
  logic               carry;
  logic               accept;
  logic               last_digit;
  logic [DIGIT_W-1:0] dig_d;
  logic               dig_cout;
  logic               dig_invalid;

  assign accept     = (state == IDLE) && start;
  assign last_digit = (idx == IW'(NDIGITS - 1));
  assign busy       = (state == ADD);
  assign done       = (state == DONE);

  // The single shared digit adder always sees the low digit of the shift registers.
  bcd_digit_add u_digit_add (
    .a       (a_sh[DIGIT_W-1:0]),
    .b       (b_sh[DIGIT_W-1:0]),
    .cin     (carry),
    .d       (dig_d),
    .cout    (dig_cout),
    .invalid (dig_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sum_bcd   <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_bcd;
      b_sh  <= b_bcd;
      idx   <= '0;
      carry <= 1'b0;
    end else if (state == ADD) begin
      // Unprocessed digits of sum_bcd keep their previous values until overwritten.
      sum_bcd[idx*DIGIT_W +: DIGIT_W] <= dig_d;
      carry <= dig_cout;
      a_sh  <= a_sh >> DIGIT_W;
      b_sh  <= b_sh >> DIGIT_W;
      idx   <= last_digit ? '0 : idx + 1'b1;
      if (last_digit) begin
        carry_out <= dig_cout;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((state == ADD) && dig_invalid) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_invalid;
  assign unused_invalid = dig_invalid;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for bcd_serial_add_ctrl (NDIGITS=4)
module tb_bcd_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         err;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_bcd = '0;
  logic [W-1:0] b_bcd = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_bcd;
  logic         carry_out;
  logic         err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .busy      (busy),
    .done      (done),
    .sum_bcd   (sum_bcd),
    .carry_out (carry_out),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic e);
    exp_t x;
    x.sum = s; x.carry = c; x.err = e; x.acc = 0;
    return x;
  endfunction

  // Reference: decimal digit-by-digit addition, LSD first.
  function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    int   s, c, ak, bk;
    c = 0; x.sum = '0; x.err = 1'b0; x.acc = 0;
    for (int k = 0; k < N; k++) begin
      ak = int'(a[4*k +: 4]);
      bk = int'(b[4*k +: 4]);
      s  = ak + bk + c;
      if (s > 9) begin x.sum[4*k +: 4] = 4'(s - 10); c = 1; end
      else       begin x.sum[4*k +: 4] = 4'(s);      c = 0; end
      if (CHK && (ak > 9 || bk > 9)) x.err = 1'b1;
    end
    x.carry = (c != 0);
    return x;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check("busy_at_done", busy, 1'b0);
      if (sb.size() == 0) begin
        check("spurious_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sum", sum_bcd, e.sum);
        check("carry", carry_out, e.carry);
        check("err", err, e.err);
        check("latency", cyc - e.acc, N);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n, nb;
    wait_idle();
    a_bcd = a; b_bcd = b; start = 1'b1;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a_bcd = W'($urandom); b_bcd = W'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("busy_cycles", nb, N);
  endtask

  initial begin
    exp_t e;
    int   n;
    logic [W-1:0] a0, b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum_bcd, '0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_sum", sum_bcd, '0);

    do_op(16'h1234, 16'h5678, mk(16'h6912, 1'b0, 1'b0));
    do_op(16'h9999, 16'h0001, mk(16'h0000, 1'b1, 1'b0));
    repeat (3) @(negedge clk);
    check("hold_sum", sum_bcd, 16'h0000);
    check("hold_carry", carry_out, 1'b1);
    do_op(16'h0505, 16'h0505, mk(16'h1010, 1'b0, 1'b0));

    // start held high; operands scrambled while the adder is busy
    wait_idle();
    a0 = rand_bcd(); b0 = rand_bcd();
    a_bcd = a0; b_bcd = b0; start = 1'b1;
    e = ref_add(a0, b0); e.acc = cyc + 1; sb.push_back(e);
    for (int i = 1; i <= N + 1; i++) begin
      @(negedge clk);
      a_bcd = W'($urandom); b_bcd = W'($urandom);
    end
    @(negedge clk);
    a0 = rand_bcd(); b0 = rand_bcd();
    a_bcd = a0; b_bcd = b0;
    e = ref_add(a0, b0); e.acc = cyc + 1; sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a_bcd = W'($urandom); b_bcd = W'($urandom);
    n = 0;
    while (sb.size() > 0 && n < 30) begin @(negedge clk); n++; end
    check("held_start_drain", sb.size(), 0);

    // reset in the second ADD cycle discards the partial result
    wait_idle();
    a_bcd = 16'h1234; b_bcd = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_sum", sum_bcd, '0);
    check("midrst_carry", carry_out, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0042, 16'h0058, mk(16'h0100, 1'b0, 1'b0));

    do_op(16'h00A0, 16'h0000, mk(16'h0100, 1'b0, CHK));
    do_op(16'h0505, 16'h0505, mk(16'h1010, 1'b0, 1'b0));
    do_op(16'hFFFF, 16'hFFFF, ref_add(16'hFFFF, 16'hFFFF));

    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin a0 = rand_bcd(); b0 = rand_bcd(); end
      else       begin a0 = W'($urandom); b0 = W'($urandom); end
      do_op(a0, b0, ref_add(a0, b0));
    end

    wait_idle();
    check("final_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
